// File: rtl/layer_sequencer.sv
// Feed-forward inference sequencer: walks layers and neurons, drives the weight ROM,
// ping-ponged neuron RAM and MAC framing, and commits each neuron after the MAC pipeline drains.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | read Nk for the current layer, validate sizes
// MAC     | one accumulate per input of the current neuron
// DRAIN   | wait out the MAC pipeline
// WRITE   | commit the neuron result to the write bank
// DONE    | one-cycle completion pulse
module layer_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int MAC_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        num_layers,
  input  logic [7:0]        num_inputs,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] neuro_read_addr,
  output logic [ADDR_W-1:0] neuro_write_addr,
  output logic              neuro_we,
  output logic              mac_en,
  output logic              mac_first,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              result_bank
);

  localparam int BANK_SIZE = 2**(ADDR_W-1);
  localparam logic [ADDR_W-1:0] BANK_B_BASE = ADDR_W'(BANK_SIZE);
  localparam logic [2:0] DRAIN_LOAD = 3'(MAC_LATENCY-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_nxt;
  logic [7:0]        n_layers_q, n_layers_nxt;
  logic [7:0]        in_count_q, in_count_nxt;
  logic [7:0]        nk_q, nk_nxt;
  logic [7:0]        layer_q, layer_nxt;
  logic [7:0]        i_q, i_nxt;
  logic [7:0]        j_q, j_nxt;
  logic [2:0]        drain_q, drain_nxt;
  logic [ADDR_W-1:0] wptr_q, wptr_nxt;
  logic              rd_bank_q, rd_bank_nxt;

  logic [ADDR_W-1:0] instr_addr_nxt, weight_addr_nxt, neuro_read_addr_nxt, neuro_write_addr_nxt;
  logic              neuro_we_nxt, mac_en_nxt, mac_first_nxt, busy_nxt, done_nxt, err_nxt;
  logic              result_bank_nxt;

  logic [ADDR_W-1:0] rd_base, wr_base;
  logic              fetch_bad;

  assign rd_base = rd_bank_q ? BANK_B_BASE : '0;
  assign wr_base = rd_bank_q ? '0 : BANK_B_BASE;
  assign fetch_bad = (instr_data == 8'd0) || (32'(instr_data) > BANK_SIZE) ||
                     (in_count_q == 8'd0) || (32'(in_count_q) > BANK_SIZE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      n_layers_q       <= '0;
      in_count_q       <= '0;
      nk_q             <= '0;
      layer_q          <= '0;
      i_q              <= '0;
      j_q              <= '0;
      drain_q          <= '0;
      wptr_q           <= '0;
      rd_bank_q        <= 1'b0;
      instr_addr       <= '0;
      weight_addr      <= '0;
      neuro_read_addr  <= '0;
      neuro_write_addr <= '0;
      neuro_we         <= 1'b0;
      mac_en           <= 1'b0;
      mac_first        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      result_bank      <= 1'b0;
    end else begin
      state_q          <= state_nxt;
      n_layers_q       <= n_layers_nxt;
      in_count_q       <= in_count_nxt;
      nk_q             <= nk_nxt;
      layer_q          <= layer_nxt;
      i_q              <= i_nxt;
      j_q              <= j_nxt;
      drain_q          <= drain_nxt;
      wptr_q           <= wptr_nxt;
      rd_bank_q        <= rd_bank_nxt;
      instr_addr       <= instr_addr_nxt;
      weight_addr      <= weight_addr_nxt;
      neuro_read_addr  <= neuro_read_addr_nxt;
      neuro_write_addr <= neuro_write_addr_nxt;
      neuro_we         <= neuro_we_nxt;
      mac_en           <= mac_en_nxt;
      mac_first        <= mac_first_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      err              <= err_nxt;
      result_bank      <= result_bank_nxt;
    end
  end

  // Outputs are computed for the state being entered so they register in step with it.
  always_comb begin
    state_nxt            = state_q;
    n_layers_nxt         = n_layers_q;
    in_count_nxt         = in_count_q;
    nk_nxt               = nk_q;
    layer_nxt            = layer_q;
    i_nxt                = i_q;
    j_nxt                = j_q;
    drain_nxt            = drain_q;
    wptr_nxt             = wptr_q;
    rd_bank_nxt          = rd_bank_q;
    instr_addr_nxt       = instr_addr;
    weight_addr_nxt      = weight_addr;
    neuro_read_addr_nxt  = neuro_read_addr;
    neuro_write_addr_nxt = neuro_write_addr;
    neuro_we_nxt         = 1'b0;
    mac_en_nxt           = 1'b0;
    mac_first_nxt        = 1'b0;
    done_nxt             = 1'b0;
    err_nxt              = err;
    result_bank_nxt      = result_bank;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_layers_nxt = num_layers;
          in_count_nxt = num_inputs;
          err_nxt      = 1'b0;
          layer_nxt    = '0;
          wptr_nxt     = '0;
          rd_bank_nxt  = 1'b0;
          if (num_layers == 8'd0) begin
            state_nxt       = S_DONE;
            done_nxt        = 1'b1;
            result_bank_nxt = 1'b0;
          end else begin
            state_nxt      = S_FETCH;
            instr_addr_nxt = '0;
          end
        end
      end

      S_FETCH: begin
        nk_nxt = instr_data;
        if (fetch_bad) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt           = S_MAC;
          j_nxt               = '0;
          weight_addr_nxt     = wptr_q;
          neuro_read_addr_nxt = rd_base;
          mac_en_nxt          = 1'b1;
          mac_first_nxt       = 1'b1;
          wptr_nxt            = wptr_q + ADDR_W'(1);
          i_nxt               = 8'd1;
        end
      end

      S_MAC: begin
        // i_q counts accumulates already issued for this neuron.
        if (i_q == in_count_q) begin
          if (MAC_LATENCY == 1) begin
            state_nxt            = S_WRITE;
            neuro_we_nxt         = 1'b1;
            neuro_write_addr_nxt = wr_base + ADDR_W'(j_q);
          end else begin
            state_nxt = S_DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end else begin
          weight_addr_nxt     = wptr_q;
          neuro_read_addr_nxt = rd_base + ADDR_W'(i_q);
          mac_en_nxt          = 1'b1;
          wptr_nxt            = wptr_q + ADDR_W'(1);
          i_nxt               = i_q + 8'd1;
        end
      end

      S_DRAIN: begin
        if (drain_q == 3'd1) begin
          state_nxt            = S_WRITE;
          neuro_we_nxt         = 1'b1;
          neuro_write_addr_nxt = wr_base + ADDR_W'(j_q);
        end else begin
          drain_nxt = drain_q - 3'd1;
        end
      end

      S_WRITE: begin
        if (j_q != nk_q - 8'd1) begin
          state_nxt           = S_MAC;
          j_nxt               = j_q + 8'd1;
          weight_addr_nxt     = wptr_q;
          neuro_read_addr_nxt = rd_base;
          mac_en_nxt          = 1'b1;
          mac_first_nxt       = 1'b1;
          wptr_nxt            = wptr_q + ADDR_W'(1);
          i_nxt               = 8'd1;
        end else if (layer_q == n_layers_q - 8'd1) begin
          state_nxt       = S_DONE;
          done_nxt        = 1'b1;
          result_bank_nxt = ~rd_bank_q;
        end else begin
          state_nxt      = S_FETCH;
          layer_nxt      = layer_q + 8'd1;
          in_count_nxt   = nk_q;
          rd_bank_nxt    = ~rd_bank_q;
          instr_addr_nxt = ADDR_W'(layer_q + 8'd1);
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_MAC) ||
               (state_nxt == S_DRAIN) || (state_nxt == S_WRITE);
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a per-cycle expected trace is built from the
// layer/neuron/input loop nest and compared against the registered outputs every cycle.
module tb_layer_sequencer;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_layers = '0;
  logic [7:0] num_inputs = '0;
  logic [7:0] instr_addr, instr_data, weight_addr, neuro_read_addr, neuro_write_addr;
  logic       neuro_we, mac_en, mac_first, busy, done, err, result_bank;

  logic [7:0] imem [256];
  assign instr_data = imem[instr_addr];

  int checks = 0;
  int errors = 0;

  layer_sequencer #(.ADDR_W(8), .MAC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_layers(num_layers), .num_inputs(num_inputs),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .weight_addr(weight_addr), .neuro_read_addr(neuro_read_addr),
    .neuro_write_addr(neuro_write_addr), .neuro_we(neuro_we),
    .mac_en(mac_en), .mac_first(mac_first), .busy(busy), .done(done),
    .err(err), .result_bank(result_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       busy, mac_en, first, we, done, err, rb, fetch;
    bit [7:0] ia, wa, ra, wra;
  } rec_t;

  rec_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pack_exp(rec_t r);
    return {25'd0, r.busy, r.mac_en, r.first, r.we, r.done, r.err,
            r.done ? r.rb : 1'b0, r.fetch ? r.ia : 8'd0,
            r.mac_en ? r.wa : 8'd0, r.mac_en ? r.ra : 8'd0, r.we ? r.wra : 8'd0};
  endfunction

  function automatic logic [63:0] pack_obs(rec_t r);
    return {25'd0, busy, mac_en, mac_first, neuro_we, done, err,
            r.done ? result_bank : 1'b0, r.fetch ? instr_addr : 8'd0,
            r.mac_en ? weight_addr : 8'd0, r.mac_en ? neuro_read_addr : 8'd0,
            r.we ? neuro_write_addr : 8'd0};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {17'd0, instr_addr, weight_addr, neuro_read_addr, neuro_write_addr,
            neuro_we, mac_en, mac_first, busy, done, err, result_bank};
  endfunction

  // Expected trace from cycle 1 onward, one record per cycle, plus one trailing idle cycle.
  task automatic build_model(input int nl, input int ni);
    rec_t r;
    int   in_c, wp, rb;
    bit   bad;
    exp_q.delete();
    in_c = ni; wp = 0; rb = 0; bad = 0;
    if (nl == 0) begin
      r = '{default: 0}; r.done = 1; r.rb = 0; exp_q.push_back(r);
    end else begin
      for (int l = 0; l < nl && !bad; l++) begin
        int nk;
        nk = imem[l];
        r = '{default: 0}; r.busy = 1; r.fetch = 1; r.ia = 8'(l); exp_q.push_back(r);
        if (nk == 0 || nk > 128 || in_c == 0 || in_c > 128) bad = 1;
        else begin
          for (int j = 0; j < nk; j++) begin
            for (int i = 0; i < in_c; i++) begin
              r = '{default: 0}; r.busy = 1; r.mac_en = 1; r.first = (i == 0);
              r.wa = 8'(wp); r.ra = 8'(rb * 128 + i); exp_q.push_back(r);
              wp = (wp + 1) % 256;
            end
            for (int d = 0; d < LAT - 1; d++) begin
              r = '{default: 0}; r.busy = 1; exp_q.push_back(r);
            end
            r = '{default: 0}; r.busy = 1; r.we = 1; r.wra = 8'((1 - rb) * 128 + j);
            exp_q.push_back(r);
          end
          in_c = nk; rb = 1 - rb;
        end
      end
      if (!bad) begin
        r = '{default: 0}; r.done = 1; r.rb = rb[0]; exp_q.push_back(r);
      end
    end
    r = '{default: 0}; r.err = bad; exp_q.push_back(r);
  endtask

  task automatic run(input int nl, input int ni, input bit extra, input int rst_at);
    build_model(nl, ni);
    @(negedge clk);
    num_layers = 8'(nl); num_inputs = 8'(ni); start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check_eq($sformatf("L%0d_N%0d_c%0d", nl, ni, k + 1), pack_obs(exp_q[k]), pack_exp(exp_q[k]));
      start = (extra && exp_q[k].busy && (k + 1 < exp_q.size())) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst_at == k + 1) begin
        start = 1'b0;
        #2 reset = 1'b1;
        #1 check_eq("reset_mid_outputs", all_outputs(), 64'd0);
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check_eq("post_reset_quiet", {60'd0, busy, neuro_we, mac_en, done}, 64'd0);
        end
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) imem[a] = 8'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_hold", all_outputs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_release", all_outputs(), 64'd0);

    imem[0] = 8'd3;
    run(1, 2, 1'b0, 0);
    imem[0] = 8'd3; imem[1] = 8'd2;
    run(2, 2, 1'b0, 0);
    imem[0] = 8'd0;
    run(1, 2, 1'b0, 0);
    imem[0] = 8'd3;
    run(1, 2, 1'b0, 0);
    run(0, 2, 1'b0, 0);
    run(1, 2, 1'b1, 0);
    run(1, 2, 1'b0, 8);
    run(1, 2, 1'b0, 0);

    imem[0] = 8'd2; imem[1] = 8'd1;
    run(2, 128, 1'b0, 0);
    run(1, 129, 1'b0, 0);
    run(1, 0, 1'b0, 0);
    imem[0] = 8'd129;
    run(1, 2, 1'b0, 0);
    imem[0] = 8'd128;
    run(1, 1, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      int nl, ni;
      nl = $urandom_range(0, 3);
      ni = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      for (int l = 0; l < 3; l++)
        imem[l] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      run(nl, ni, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
